// File: rtl/cache_pkg.sv
// Shared L1/L2 cache definitions: controller states, default
// geometry shared with L2 and the packed block type.
package cache_pkg;
  localparam int DFLT_DATA_WIDTH = 32;
  localparam int DFLT_ADDR_WIDTH = 11;
  localparam int DFLT_BLOCK_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WRITE_THRU
  } state_t;

  typedef logic [DFLT_BLOCK_SIZE*DFLT_DATA_WIDTH-1:0] block_t;
endpackage

// File: rtl/l1_cache_if.sv
// CPU load/store port and L1->L2 block request port bundles.
// master drives the request side, slave answers it.
interface l1_cpu_if #(
  parameter int DATA_WIDTH = cache_pkg::DFLT_DATA_WIDTH,
  parameter int ADDR_WIDTH = cache_pkg::DFLT_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_ready;
  logic                  cpu_hit;

  modport master (
    output cpu_addr, cpu_data_in, cpu_read, cpu_write,
    input  cpu_data_out, cpu_ready, cpu_hit
  );
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_read, cpu_write,
    output cpu_data_out, cpu_ready, cpu_hit
  );
endinterface

interface l1_l2_if #(
  parameter int DATA_WIDTH = cache_pkg::DFLT_DATA_WIDTH,
  parameter int ADDR_WIDTH = cache_pkg::DFLT_ADDR_WIDTH,
  parameter int BLOCK_SIZE = cache_pkg::DFLT_BLOCK_SIZE
);
  logic [ADDR_WIDTH-1:0]            l2_addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out;
  logic                             l2_read;
  logic                             l2_write;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data;
  logic                             l2_block_valid;
  logic                             l2_ready;

  modport master (
    output l2_addr, l2_data_out, l2_read, l2_write,
    input  l2_block_data, l2_block_valid, l2_ready
  );
  modport slave (
    input  l2_addr, l2_data_out, l2_read, l2_write,
    output l2_block_data, l2_block_valid, l2_ready
  );
endinterface

// File: rtl/l1_line_store.sv
// L1 tag/valid/data arrays: combinational lookup, synchronous
// line install and word merge; only valid bits are reset.
module l1_line_store #(
  parameter int DW    = 32,
  parameter int TW    = 4,
  parameter int IW    = 2,
  parameter int OW    = 5,
  parameter int LINES = 4,
  parameter int BS    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    i_idx,
  input  logic [TW-1:0]    i_tag,
  output logic             o_hit,
  output logic [BS*DW-1:0] o_line,
  input  logic             i_fill,
  input  logic [BS*DW-1:0] i_fill_line,
  input  logic             i_merge,
  input  logic [OW-1:0]    i_off,
  input  logic [DW-1:0]    i_word
);
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [BS*DW-1:0] r_data [LINES];

  assign o_hit  = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
  assign o_line = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_fill) r_valid[i_idx] <= 1'b1;
  end

  // A merge in the install cycle lands on top of the new line
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_fill_line;
    end
    if (i_merge) r_data[i_idx][i_off*DW +: DW] <= i_word;
  end
endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-through/write-allocate L1 data cache.
// Define L1_STATS_EN to add saturating hit_count/miss_count ports.
module l1_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DFLT_ADDR_WIDTH,
  parameter int CACHE_SIZE = 128,
  parameter int BLOCK_SIZE = DFLT_BLOCK_SIZE
) (
  input logic     clk,
  input logic     rst,
  l1_cpu_if.slave cpu,
  l1_l2_if.master l2
`ifdef L1_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int OW    = $clog2(BLOCK_SIZE);
  localparam int IW    = $clog2(LINES);
  localparam int TW    = ADDR_WIDTH - OW - IW;
  localparam int BW    = BLOCK_SIZE * DATA_WIDTH;

  state_t r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic r_wr, r_hit, w_hit_nxt;

  logic [DATA_WIDTH-1:0] r_cpu_data, w_cpu_data_nxt;
  logic r_cpu_ready, w_cpu_ready_nxt;
  logic r_cpu_hit, w_cpu_hit_nxt;
  logic [ADDR_WIDTH-1:0] r_l2_addr, w_l2_addr_nxt;
  logic [BW-1:0] r_l2_data, w_l2_data_nxt;
  logic r_l2_read, w_l2_read_nxt;
  logic r_l2_write, w_l2_write_nxt;

  logic [OW-1:0] w_off;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [ADDR_WIDTH-1:0] w_blk_addr;
  logic [BW-1:0] w_line, w_base, w_merged;
  logic w_hit, w_fill, w_merge, w_accept, w_l2_done;

  assign w_off      = r_addr[OW-1:0];
  assign w_idx      = r_addr[OW+IW-1:OW];
  assign w_tag      = r_addr[ADDR_WIDTH-1:OW+IW];
  assign w_blk_addr = {w_tag, w_idx, {OW{1'b0}}};
  assign w_accept   = (cpu.cpu_read | cpu.cpu_write) & ~r_cpu_ready;
  assign w_l2_done  = l2.l2_ready & l2.l2_block_valid;

  l1_line_store #(
    .DW(DATA_WIDTH), .TW(TW), .IW(IW),
    .OW(OW), .LINES(LINES), .BS(BLOCK_SIZE)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (w_idx),
    .i_tag       (w_tag),
    .o_hit       (w_hit),
    .o_line      (w_line),
    .i_fill      (w_fill & ~rst),
    .i_fill_line (l2.l2_block_data),
    .i_merge     (w_merge & ~rst),
    .i_off       (w_off),
    .i_word      (r_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cpu_data_nxt  = r_cpu_data;
    w_cpu_ready_nxt = 1'b0;
    w_cpu_hit_nxt   = 1'b0;
    w_l2_addr_nxt   = r_l2_addr;
    w_l2_data_nxt   = r_l2_data;
    w_l2_read_nxt   = r_l2_read;
    w_l2_write_nxt  = r_l2_write;
    w_hit_nxt       = r_hit;
    w_fill          = 1'b0;
    w_merge         = 1'b0;
    w_base   = (r_state == REFILL) ? l2.l2_block_data : w_line;
    w_merged = w_base;
    w_merged[w_off*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    unique case (r_state)
      IDLE: if (w_accept) w_state_nxt = LOOKUP;
      LOOKUP: begin
        if (w_hit && !r_wr) begin
          w_cpu_data_nxt  = w_line[w_off*DATA_WIDTH +: DATA_WIDTH];
          w_cpu_ready_nxt = 1'b1;
          w_cpu_hit_nxt   = 1'b1;
          w_state_nxt     = IDLE;
        end else if (w_hit) begin
          w_merge        = 1'b1;
          w_l2_write_nxt = 1'b1;
          w_l2_addr_nxt  = w_blk_addr;
          w_l2_data_nxt  = w_merged;
          w_hit_nxt      = 1'b1;
          w_state_nxt    = WRITE_THRU;
        end else begin
          w_l2_read_nxt = 1'b1;
          w_l2_addr_nxt = w_blk_addr;
          w_state_nxt   = REFILL;
        end
      end
      REFILL: if (w_l2_done) begin
        w_fill        = 1'b1;
        w_l2_read_nxt = 1'b0;
        if (r_wr) begin
          w_merge        = 1'b1;
          w_l2_write_nxt = 1'b1;
          w_l2_data_nxt  = w_merged;
          w_hit_nxt      = 1'b0;
          w_state_nxt    = WRITE_THRU;
        end else begin
          w_cpu_data_nxt =
            l2.l2_block_data[w_off*DATA_WIDTH +: DATA_WIDTH];
          w_cpu_ready_nxt = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      WRITE_THRU: if (l2.l2_ready) begin
        w_l2_write_nxt  = 1'b0;
        w_cpu_ready_nxt = 1'b1;
        w_cpu_hit_nxt   = r_hit;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_hit       <= 1'b0;
      r_cpu_data  <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_hit   <= 1'b0;
      r_l2_addr   <= '0;
      r_l2_data   <= '0;
      r_l2_read   <= 1'b0;
      r_l2_write  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_addr  <= cpu.cpu_addr;
        r_wdata <= cpu.cpu_data_in;
        r_wr    <= cpu.cpu_write;
      end
      r_hit       <= w_hit_nxt;
      r_cpu_data  <= w_cpu_data_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_cpu_hit   <= w_cpu_hit_nxt;
      r_l2_addr   <= w_l2_addr_nxt;
      r_l2_data   <= w_l2_data_nxt;
      r_l2_read   <= w_l2_read_nxt;
      r_l2_write  <= w_l2_write_nxt;
    end
  end

  assign cpu.cpu_data_out = r_cpu_data;
  assign cpu.cpu_ready    = r_cpu_ready;
  assign cpu.cpu_hit      = r_cpu_hit;
  assign l2.l2_addr       = r_l2_addr;
  assign l2.l2_data_out   = r_l2_data;
  assign l2.l2_read       = r_l2_read;
  assign l2.l2_write      = r_l2_write;

`ifdef L1_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_cpu_ready_nxt) begin
      if (w_cpu_hit_nxt && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (!w_cpu_hit_nxt && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: refill, hit, write-through,
// conflict, write-miss and mid-refill reset scenarios.
module tb_l1_cache;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_cpu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) cpu_if ();
  l1_l2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11),
             .BLOCK_SIZE(32)) l2_if ();

`ifdef L1_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  l1_cache #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11),
    .CACHE_SIZE(128), .BLOCK_SIZE(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_if),
    .l2  (l2_if)
`ifdef L1_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  int ovl_cyc = 0;

  always @(negedge clk) begin
    if (l2_if.l2_read) rd_cyc++;
    if (l2_if.l2_write) wr_cyc++;
    if (l2_if.l2_read && l2_if.l2_write) ovl_cyc++;
  end

  task automatic check(input string tag,
                       input logic [1023:0] obs,
                       input logic [1023:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic block_t mkblk(input logic [31:0] base);
    block_t b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = base + i;
    return b;
  endfunction

  task automatic req(input logic wr, input logic [10:0] a,
                     input logic [31:0] d);
    @(posedge clk);
    #1;
    cpu_if.cpu_addr    = a;
    cpu_if.cpu_data_in = d;
    cpu_if.cpu_read    = !wr;
    cpu_if.cpu_write   = wr;
  endtask

  // Returns at the negedge where cpu_ready is seen, request dropped
  task automatic wait_ready(input string tag, output int cyc);
    logic ok;
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_if.cpu_ready) begin
        ok = 1'b1;
        break;
      end
    end
    cpu_if.cpu_read  = 1'b0;
    cpu_if.cpu_write = 1'b0;
    check({tag, "_ready_seen"}, ok, 1'b1);
  endtask

  task automatic wait_l2(input string tag, input logic wr);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr ? l2_if.l2_write : l2_if.l2_read) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_l2_req_seen"}, ok, 1'b1);
  endtask

  task automatic pulse_l2(input block_t blk, input logic vld);
    l2_if.l2_block_data  = blk;
    l2_if.l2_ready       = 1'b1;
    l2_if.l2_block_valid = vld;
    @(posedge clk);
    #1;
    l2_if.l2_ready       = 1'b0;
    l2_if.l2_block_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int rd0, wr0;
    block_t exp_blk;

    rst = 1'b1;
    cpu_if.cpu_addr      = '0;
    cpu_if.cpu_data_in   = '0;
    cpu_if.cpu_read      = 1'b0;
    cpu_if.cpu_write     = 1'b0;
    l2_if.l2_block_data  = '0;
    l2_if.l2_block_valid = 1'b0;
    l2_if.l2_ready       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_ready", cpu_if.cpu_ready, 1'b0);
    check("rst_cpu_hit", cpu_if.cpu_hit, 1'b0);
    check("rst_cpu_data", cpu_if.cpu_data_out, 32'h0);
    check("rst_l2_read", l2_if.l2_read, 1'b0);
    check("rst_l2_write", l2_if.l2_write, 1'b0);
    check("rst_l2_addr", l2_if.l2_addr, 11'h0);
    check("rst_l2_data", l2_if.l2_data_out, '0);

    // Cold read miss; a ready-only pulse must not complete it
    req(1'b0, 11'h045, 32'h0);
    wait_l2("cold", 1'b0);
    check("cold_l2_addr", l2_if.l2_addr, 11'h040);
    check("cold_no_write", l2_if.l2_write, 1'b0);
    pulse_l2(mkblk(32'h100), 1'b0);
    @(negedge clk);
    check("ready_wo_valid_ignored", l2_if.l2_read, 1'b1);
    pulse_l2(mkblk(32'h100), 1'b1);
    wait_ready("cold", cyc);
    check("cold_ready_latency", cyc, 1);
    check("cold_l2_read_dropped", l2_if.l2_read, 1'b0);
    check("cold_data", cpu_if.cpu_data_out, 32'h105);
    check("cold_hit", cpu_if.cpu_hit, 1'b0);

    // Read hit: sampled at N, ready in N+2 (3rd negedge from drive)
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    req(1'b0, 11'h047, 32'h0);
    wait_ready("hit047", cyc);
    check("hit047_latency", cyc, 3);
    check("hit047_data", cpu_if.cpu_data_out, 32'h107);
    check("hit047_hit", cpu_if.cpu_hit, 1'b1);
    check("hit047_no_l2", (rd_cyc - rd0) + (wr_cyc - wr0), 0);
    @(negedge clk);
    check("hit047_ready_pulse", cpu_if.cpu_ready, 1'b0);

    // Write hit with write-through of the full merged block
    exp_blk = mkblk(32'h100);
    exp_blk[1*32 +: 32] = 32'hDEADBEEF;
    req(1'b1, 11'h041, 32'hDEADBEEF);
    wait_l2("wh", 1'b1);
    check("wh_l2_addr", l2_if.l2_addr, 11'h040);
    check("wh_l2_block", l2_if.l2_data_out, exp_blk);
    check("wh_no_read", l2_if.l2_read, 1'b0);
    pulse_l2('0, 1'b0);
    wait_ready("wh", cyc);
    check("wh_ready_latency", cyc, 1);
    check("wh_hit", cpu_if.cpu_hit, 1'b1);
    check("wh_l2_write_dropped", l2_if.l2_write, 1'b0);

    rd0 = rd_cyc;
    req(1'b0, 11'h041, 32'h0);
    wait_ready("rh041", cyc);
    check("rh041_data", cpu_if.cpu_data_out, 32'hDEADBEEF);
    check("rh041_hit", cpu_if.cpu_hit, 1'b1);
    check("rh041_no_l2_read", rd_cyc - rd0, 0);

    // Conflict on index 2 evicts the 0x040 line
    req(1'b0, 11'h0C0, 32'h0);
    wait_l2("cf", 1'b0);
    check("cf_l2_addr", l2_if.l2_addr, 11'h0C0);
    pulse_l2(mkblk(32'h200), 1'b1);
    wait_ready("cf", cyc);
    check("cf_data", cpu_if.cpu_data_out, 32'h200);
    check("cf_hit", cpu_if.cpu_hit, 1'b0);

    req(1'b0, 11'h045, 32'h0);
    wait_l2("re045", 1'b0);
    check("re045_l2_addr", l2_if.l2_addr, 11'h040);
    pulse_l2(exp_blk, 1'b1);
    wait_ready("re045", cyc);
    check("re045_data", cpu_if.cpu_data_out, 32'h105);
    check("re045_hit", cpu_if.cpu_hit, 1'b0);

    // Write miss: refill then write-through with word0 replaced
    req(1'b1, 11'h120, 32'h5);
    wait_l2("wm", 1'b0);
    check("wm_rd_addr", l2_if.l2_addr, 11'h120);
    pulse_l2(mkblk(32'h300), 1'b1);
    wait_l2("wm", 1'b1);
    exp_blk = mkblk(32'h300);
    exp_blk[0 +: 32] = 32'h5;
    check("wm_wr_addr", l2_if.l2_addr, 11'h120);
    check("wm_wr_block", l2_if.l2_data_out, exp_blk);
    pulse_l2('0, 1'b0);
    wait_ready("wm", cyc);
    check("wm_hit", cpu_if.cpu_hit, 1'b0);
    check("no_rd_wr_overlap", ovl_cyc, 0);

    // Reset in the middle of a refill (index 1, tag 3 misses)
    req(1'b0, 11'h1A0, 32'h0);
    wait_l2("mid", 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_if.cpu_read = 1'b0;
    @(negedge clk);
    check("mid_rst_state", dut.r_state, IDLE);
    check("mid_rst_l2_read", l2_if.l2_read, 1'b0);
    check("mid_rst_l2_write", l2_if.l2_write, 1'b0);
    check("mid_rst_l2_addr", l2_if.l2_addr, 11'h0);
    check("mid_rst_l2_data", l2_if.l2_data_out, '0);
    check("mid_rst_cpu_data", cpu_if.cpu_data_out, 32'h0);
    check("mid_rst_cpu_ready", cpu_if.cpu_ready, 1'b0);
    check("mid_rst_cpu_hit", cpu_if.cpu_hit, 1'b0);

    req(1'b0, 11'h045, 32'h0);
    wait_l2("post", 1'b0);
    check("post_l2_addr", l2_if.l2_addr, 11'h040);
    pulse_l2(mkblk(32'h100), 1'b1);
    wait_ready("post", cyc);
    check("post_data", cpu_if.cpu_data_out, 32'h105);
    check("post_hit", cpu_if.cpu_hit, 1'b0);

`ifdef L1_STATS_EN
    @(negedge clk);
    check("stats_hit", hit_count, 16'd0);
    check("stats_miss", miss_count, 16'd1);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
# l1_cache

Direct-mapped, write-through, write-allocate L1 data cache sitting between the CPU load/store port and `L2_cache`. It serves single-word CPU reads and writes from a small line store and refills whole blocks from L2. It forwards every write to L2 as a full updated block, since L2 accepts block writes only. It is the requester on L2's `l1_cache_*` interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bits per word
- `ADDR_WIDTH`, 11, word address width (matches L2)
- `CACHE_SIZE`, 128, words in L1
- `BLOCK_SIZE`, 32, words per block (must equal L2's)

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `cpu_addr` in ADDR_WIDTH — word address
- `cpu_data_in` in DATA_WIDTH — store data
- `cpu_read` in 1 — load request, held until `cpu_ready`
- `cpu_write` in 1 — store request, held until `cpu_ready`
- `cpu_data_out` out DATA_WIDTH — load data, valid while `cpu_ready`
- `cpu_ready` out 1 — one-cycle completion pulse
- `cpu_hit` out 1 — qualifies `cpu_ready`: 1 means L1 hit
- `l2_addr` out ADDR_WIDTH — block-aligned address, drives `l1_cache_addr`
- `l2_data_out` out BLOCK_SIZE*DATA_WIDTH — block for write-through, drives `l1_cache_data_in`
- `l2_read` out 1, `l2_write` out 1 — drive `l1_cache_read` / `l1_cache_write`
- `l2_block_data` in BLOCK_SIZE*DATA_WIDTH — from `l1_block_data_out`
- `l2_block_valid` in 1, `l2_ready` in 1 — from `l1_block_valid` / `l1_cache_ready`

## Operation
- Derived values: LINES = CACHE_SIZE/BLOCK_SIZE. Offset = low clog2(BLOCK_SIZE) bits, then index = clog2(LINES) bits, tag = the remainder.
- FSM states:
  - IDLE: accepts on `cpu_read|cpu_write` and latches address, data and op. A write wins if both are high. No request is accepted in a cycle where `cpu_ready` is high. Next state LOOKUP.
  - LOOKUP: hit = valid & tag match.
    - Read hit: `cpu_data_out` = word[offset], `cpu_ready`=1, `cpu_hit`=1, then IDLE.
    - Write hit: merge the word into the line, then WRITE_THRU.
    - Miss: REFILL.
  - REFILL: holds `l2_read`=1 and `l2_addr`={tag,index,0}.
    - Completes only on `l2_ready & l2_block_valid`; `l2_ready` alone is ignored.
    - On completion: install the block, set tag and valid, overwriting the old line (no writeback needed).
    - Read: respond with word[offset], `cpu_hit`=0, then IDLE.
    - Write: merge the word, then WRITE_THRU with hit flag 0.
  - WRITE_THRU: holds `l2_write`=1, `l2_addr`={tag,index,0}, `l2_data_out`=updated line until `l2_ready`. Then `cpu_ready`=1 with `cpu_hit` = saved hit flag, then IDLE.
- `l2_read` and `l2_write` are never high together.
- Reset (at any time, including mid-refill): state IDLE, all valid bits cleared. All outputs 0: `cpu_data_out`, `cpu_ready`, `cpu_hit`, `l2_addr`, `l2_data_out`, `l2_read`, `l2_write`. Any L2 transaction in flight is abandoned.
- Tag and data arrays are not reset.

## Timing
- All outputs are registered.
- Read hit: request sampled at edge N, LOOKUP in cycle N+1, `cpu_ready` high for exactly cycle N+2.
- Read miss: `l2_read` rises in the cycle after LOOKUP. `cpu_ready` follows one cycle after the edge sampling `l2_ready & l2_block_valid`.
- Write: `cpu_ready` follows one cycle after the edge sampling `l2_ready` in WRITE_THRU.
- The L2 request stays asserted until L2's ready pulse. It drops in the cycle after the pulse is sampled, so L2 sees no spurious second request.
- CPU must drop its request in the cycle `cpu_ready` is high.

## Configuration
- `L1_STATS_EN` defined: adds output ports `hit_count` and `miss_count`, 16 bits each, reset to 0.
  - Each increments once per completed CPU access, by hit flag.
  - Saturates at 0xFFFF.
- `L1_STATS_EN` undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `cache_pkg` holds:
  - FSM state enum (IDLE, LOOKUP, REFILL, WRITE_THRU)
  - default DATA_WIDTH, ADDR_WIDTH and BLOCK_SIZE constants, shared with L2
  - `block_t` packed block typedef
- One sub-module, `l1_line_store`:
  - tag, valid and data arrays
  - combinational read port: tag match and line out
  - synchronous write port: full-line install, single-word merge, valid clear on `rst`

## Test plan
- Cold read of 0x045 -> `l2_read`=1 with `l2_addr`=0x040. L2 returns words i=0x100+i. Response `cpu_data_out`=0x105, `cpu_hit`=0.
- Read 0x047 after the above -> no L2 traffic, `cpu_ready` two cycles after request, `cpu_data_out`=0x107, `cpu_hit`=1.
- Write 0x041 = 0xDEADBEEF (hit) -> `l2_write` with `l2_addr`=0x040 and block word1=0xDEADBEEF, others unchanged. `cpu_hit`=1. A following read of 0x041 hits and returns 0xDEADBEEF.
- Conflict: read 0x0C0 (same index 2, tag 1) -> miss, line replaced. Then read 0x045 misses again with `l2_addr`=0x040.
- Write miss 0x120 = 0x5 -> REFILL from 0x120, then WRITE_THRU with word0=0x5, `cpu_hit`=0. `l2_read` and `l2_write` never overlap.
- Assert `rst` during REFILL -> next cycle all outputs 0, state IDLE. Re-reading 0x045 misses.
